// File: rtl/tone_pkg.sv
// Shared types and sizes for the tone detector slice.
// Counter width, FSM states, averaging depth and a deviation helper.
package tone_pkg;

    localparam int CNT_W     = 20;
    localparam int AVG_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    // One extra bit so the subtraction can never wrap.
    function automatic logic [CNT_W:0] abs_diff(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] ea;
        logic [CNT_W:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

endpackage

// File: rtl/tone_detector_if.sv
// Sample stream in, half-period measurement and status out.
// master = sample source / consumer, slave = tone detector.
interface tone_detector_if;
    import tone_pkg::*;

    logic                    sample_en;
    logic signed [31:0]      sample;
    logic [CNT_W-1:0]        half_wavelength;
    logic                    measure_valid;
    logic                    phase;
    logic                    sound_on;
    logic                    locked;

    modport master (
        output sample_en,
        output sample,
        input  half_wavelength,
        input  measure_valid,
        input  phase,
        input  sound_on,
        input  locked
    );

    modport slave (
        input  sample_en,
        input  sample,
        output half_wavelength,
        output measure_valid,
        output phase,
        output sound_on,
        output locked
    );

endinterface

// File: rtl/interval_averager.sv
// Four-deep interval history with running sum; used only when
// TONE_DETECT_AVG_EN is defined. dout is the value to report for din.
module interval_averager
    import tone_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [CNT_W-1:0] din,
    output logic [CNT_W-1:0] dout
);

    logic [CNT_W-1:0] hist [AVG_DEPTH];
    logic [21:0]      sum;
    logic [21:0]      sum_next;
    logic [2:0]       fill;

    // Oldest entry stays zero until the history is full.
    always_comb begin
        sum_next = sum + 22'(din) - 22'(hist[AVG_DEPTH-1]);
        dout     = din;
        if (fill >= 3'(AVG_DEPTH - 1))
            dout = 20'(sum_next >> 2);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum  <= '0;
            fill <= '0;
            for (int i = 0; i < AVG_DEPTH; i++)
                hist[i] <= '0;
        end else if (push) begin
            hist[0] <= din;
            for (int i = 1; i < AVG_DEPTH; i++)
                hist[i] <= hist[i-1];
            sum <= sum_next;
            if (fill != 3'(AVG_DEPTH))
                fill <= fill + 3'd1;
        end
    end

endmodule

// File: rtl/tone_detector.sv
// Square-wave tone detector: hysteresis phase recovery, half-period
// measurement and lock tracking. TONE_DETECT_AVG_EN adds averaging.
module tone_detector
    import tone_pkg::*;
#(
    parameter logic signed [31:0] THRESHOLD = 32'sd5_000_000,
    parameter logic [19:0]        TOLERANCE = 20'd2,
    parameter logic [19:0]        TIMEOUT   = 20'hFFFFF
) (
    input logic            clk,
    input logic            reset,
    tone_detector_if.slave bus
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] prev;
    logic             prev_valid;
    logic [CNT_W-1:0] hw_q;
    logic             mv_q;
    logic             phase_q;
    logic             sound_q;
    logic             locked_q;

    logic             crossing;
    logic             stable;
    logic             timeout;
    logic [CNT_W-1:0] report;

    assign crossing = bus.sample_en &&
                      (phase_q ? (bus.sample < -THRESHOLD)
                               : (bus.sample > THRESHOLD));
    assign stable   = abs_diff(cnt, prev) <= {1'b0, TOLERANCE};
    assign timeout  = (cnt == TIMEOUT - 20'd1);

`ifdef TONE_DETECT_AVG_EN
    interval_averager u_avg (
        .clk   (clk),
        .reset (reset),
        .clear (state != LOCKED),
        .push  (crossing && state == LOCKED && stable),
        .din   (cnt),
        .dout  (report)
    );
`else
    assign report = cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            hw_q       <= '0;
            mv_q       <= 1'b0;
            phase_q    <= 1'b0;
            sound_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            mv_q <= 1'b0;
            if (crossing) begin
                phase_q <= ~phase_q;
                cnt     <= '0;
                unique case (state)
                    IDLE: begin
                        state   <= ACQUIRE;
                        sound_q <= 1'b1;
                    end
                    ACQUIRE: begin
                        hw_q       <= cnt;
                        mv_q       <= 1'b1;
                        prev       <= cnt;
                        prev_valid <= 1'b1;
                        if (prev_valid && stable) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        mv_q <= 1'b1;
                        prev <= cnt;
                        if (stable) begin
                            hw_q <= report;
                        end else begin
                            hw_q     <= cnt;
                            state    <= ACQUIRE;
                            locked_q <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                if (cnt != TIMEOUT)
                    cnt <= cnt + 20'd1;
                if (state != IDLE && timeout) begin
                    state      <= IDLE;
                    sound_q    <= 1'b0;
                    locked_q   <= 1'b0;
                    prev       <= '0;
                    prev_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.half_wavelength = hw_q;
    assign bus.measure_valid   = mv_q;
    assign bus.phase           = phase_q;
    assign bus.sound_on        = sound_q;
    assign bus.locked          = locked_q;

endmodule
